// File: rtl/gcd_lcm_stage.sv
`default_nettype none
// ============================================================================
//  Module  : gcd_lcm_stage
//  Brief   : LCM = (|P| / G) * |Q| using a restoring divider and shift-add
//            multiplier, with an error flag for a zero or non-dividing G.
//  Revision: 1.0  initial release
// ============================================================================
module gcd_lcm_stage #(
    parameter int W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W:0]     p,
    input  logic [W:0]     q,
    input  logic [W:0]     g,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] lcm,
    output logic           err
);

    localparam int            CW     = $clog2(W + 1);
    localparam logic [CW-1:0] c_last = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_pm;
    logic [W-1:0]     r_qm;
    logic [W-1:0]     r_gm;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quot;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_lcm;
    logic             r_err;

    logic [W:0]       w_shift;
    logic [W:0]       w_diff;
    logic             w_ge;
    logic [W-1:0]     w_rem_nxt;
    logic [2*W-1:0]   w_addend;
    logic [2*W-1:0]   w_acc_nxt;
    logic             w_unused;

    // Sign bits carry no information for a magnitude-only result.
    assign w_unused = ^{p[W], q[W], g[W]};

    // One restoring-division step; the extra top bit keeps the compare exact.
    assign w_shift   = {r_rem, r_pm[W-1]};
    assign w_diff    = w_shift - {1'b0, r_gm};
    assign w_ge      = (w_shift >= {1'b0, r_gm});
    assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];

    assign w_addend  = {{W{1'b0}}, r_quot} << r_cnt;
    assign w_acc_nxt = r_qm[0] ? (r_acc + w_addend) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pm    <= '0;
            r_qm    <= '0;
            r_gm    <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_lcm   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pm <= p[W-1:0];
                        r_qm <= q[W-1:0];
                        r_gm <= g[W-1:0];
                        if (p[W-1:0] == '0 || q[W-1:0] == '0) begin
                            r_lcm   <= '0;
                            r_err   <= 1'b0;
                            r_state <= S_DONE;
                        end else if (g[W-1:0] == '0) begin
                            r_lcm   <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quot  <= '0;
                            r_cnt   <= '0;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= {r_quot[W-2:0], w_ge};
                    r_pm   <= r_pm << 1;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= S_MUL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MUL: begin
                    // Divisibility is judged from the registered remainder,
                    // keeping the zero-detect off the subtractor path.
                    if (r_rem != '0) begin
                        r_lcm   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_qm  <= r_qm >> 1;
                        if (r_cnt == c_last) begin
                            r_lcm   <= w_acc_nxt;
                            r_err   <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign lcm       = r_lcm;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_lcm_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_gcd_lcm_stage
//  Brief   : Directed and random jobs against an arithmetic LCM model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_gcd_lcm_stage;

    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W:0]     p;
    logic [W:0]     q;
    logic [W:0]     g;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] lcm;
    logic           err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gcd_lcm_stage #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .q         (q),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lcm       (lcm),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job; hold>0 keeps out_ready low that many cycles in DONE while
    // a competing request is presented.
    task automatic do_job(input logic [7:0] tp, input logic [7:0] tq,
                          input logic [7:0] tg, input int hold);
        int pm, qm, gm, elcm, eerr, elat, lat, n;
        bit busy_rdy;
        pm = int'(tp[6:0]);
        qm = int'(tq[6:0]);
        gm = int'(tg[6:0]);
        if (pm == 0 || qm == 0) begin
            elcm = 0; eerr = 0; elat = 0;
        end else if (gm == 0) begin
            elcm = 0; eerr = 1; elat = 0;
        end else if (pm % gm != 0) begin
            elcm = 0; eerr = 1; elat = W + 1;
        end else begin
            elcm = (pm / gm) * qm; eerr = 0; elat = 2 * W;
        end

        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_job", {31'b0, in_ready}, 32'd1);

        p = tp; q = tq; g = tg;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;

        lat = 0;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 4 * W) begin
            busy_rdy |= in_ready;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, elat);
        chk("lcm", {18'b0, lcm}, elcm);
        chk("err", {31'b0, err}, eerr);
        chk("in_ready_while_busy", {31'b0, busy_rdy}, 32'd0);

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                p = 8'h06; q = 8'h04; g = 8'h02;
                in_valid = 1'b1;
                @(negedge clk);
                chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_lcm", {18'b0, lcm}, elcm);
                chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end

        @(negedge clk);
        chk("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
        chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rp, rq, rg;
        int k, gd;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        p = '0; q = '0; g = '0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_lcm", {18'b0, lcm}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_job(8'd12,  8'd18,  8'd6, 0);
        do_job(8'h8C,  8'h92,  8'd6, 0);
        do_job(8'd0,   8'd5,   8'd5, 0);
        do_job(8'd3,   8'd4,   8'd0, 0);
        do_job(8'd10,  8'd4,   8'd3, 0);
        do_job(8'd127, 8'd126, 8'd1, 5);
        do_job(8'd6,   8'd4,   8'd2, 0);
        do_job(8'd12,  8'd18,  8'd6, 0);

        // Abort a 12/18/6 job mid-division.
        p = 8'd12; q = 8'd18; g = 8'd6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_lcm", {18'b0, lcm}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_job(8'd4, 8'd6, 8'd2, 0);

        for (int i = 0; i < 20; i++) begin
            rg = 8'($urandom_range(0, 20));
            gd = (rg == 8'd0) ? 1 : int'(rg);
            if ($urandom_range(0, 1) == 1) begin
                k  = $urandom_range(0, 127 / gd);
                rp = 8'(gd * k);
            end else begin
                rp = 8'($urandom_range(0, 127));
            end
            rp[7] = 1'($urandom_range(0, 1));
            rg[7] = 1'($urandom_range(0, 1));
            rq    = 8'($urandom);
            do_job(rp, rq, rg, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
